fc_tile_accum_layer: RTL and testbench

Parametrised fully-connected layer controller, the successor to the single-mode FC layer in the LeNet-class CIM tops. It buffers one input vector, streams it row-by-row into a grid of `v_cim_tiles × h_cim_tiles` crossbars, and starts the analogue MVM. It then reads each output column, accumulates the partial sums across vertical tiles and requantises (shift, optional ReLU, saturate). Results leave one at a time through a valid/busy handshake. It sits between a producer layer's output stream and the next layer's input buffer.

---
 rtl/cim_pkg.sv | 46 ++++
 rtl/fc_tile_accum_layer_if.sv | 19 +
 rtl/fc_tile_accum_layer_tile_accum.sv | 37 +++
 rtl/fc_tile_accum_layer.sv | 155 +++++++++++++++
 tb/tb_fc_tile_accum_layer.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/cim_pkg.sv
// cim_pkg: types and helpers shared by the FC tile-accumulate layer.
//   state_e   - controller FSM states
//   ceil_div  - integer ceiling division, used for the tile counts
//   clog2_min1- address width that never collapses to zero bits
//   requant   - shift / ReLU / saturate of an accumulated column sum
package cim_pkg;

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_FIRE, S_WAIT, S_ADDR, S_CAPT, S_EMIT
    } state_e;

    typedef struct packed {
        logic [31:0] data;
        logic        sat;
    } rq_t;

    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Negative sums always produce 0; they only count as saturation when
    // ReLU is off, because with ReLU the clamp is the intended behaviour.
    function automatic rq_t requant(input logic signed [63:0] sum, input int sh,
                                    input bit relu_en, input int out_w);
        logic signed [63:0] s;
        logic signed [63:0] maxv;
        rq_t r;
        s    = sum >>> sh;
        maxv = (64'sd1 <<< out_w) - 64'sd1;
        r    = '0;
        if (s < 0) begin
            r.sat = ~relu_en;
        end else if (s > maxv) begin
            r.data = maxv[31:0];
            r.sat  = 1'b1;
        end else begin
            r.data = s[31:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/fc_tile_accum_layer_if.sv
// fc_tile_accum_layer_if: result stream from the layer to the next layer.
//   o_func_valid/o_func_data/o_func_idx/o_sat - result held while valid
//   i_next_busy                               - consumer stall
// master = producing layer, slave = consumer.
interface fc_tile_accum_layer_if #(
    parameter int OUT_W = 2,
    parameter int IDX_W = 7
);
    logic             o_func_valid;
    logic [OUT_W-1:0] o_func_data;
    logic [IDX_W-1:0] o_func_idx;
    logic             o_sat;
    logic             i_next_busy;

    modport master (output o_func_valid, o_func_data, o_func_idx, o_sat,
                    input  i_next_busy);
    modport slave  (input  o_func_valid, o_func_data, o_func_idx, o_sat,
                    output i_next_busy);
endinterface

// File: rtl/fc_tile_accum_layer_tile_accum.sv
// tile_accum: sums one output column across all vertical tiles (signed)
// and requantises the result. Purely combinational.
//   col  - one acc-wide column result per vertical tile
//   data - requantised unsigned result
//   sat  - result was clipped
module tile_accum
    import cim_pkg::*;
#(
    parameter int V       = 1,
    parameter int ACC_W   = 16,
    parameter int OUT_W   = 2,
    parameter int SHIFT   = 0,
    parameter bit RELU_EN = 1'b1
) (
    input  logic [V-1:0][ACC_W-1:0] col,
    output logic [OUT_W-1:0]        data,
    output logic                    sat
);
    // One guard bit beyond the growth of V terms keeps the sum exact.
    localparam int SUM_W = ACC_W + $clog2(V) + 1;

    logic signed [SUM_W-1:0] sum;
    rq_t                     rq;

    always_comb begin
        sum = '0;
        for (int v = 0; v < V; v++) begin
            sum = sum + SUM_W'($signed(col[v]));
        end
    end

    assign rq   = requant(64'(sum), SHIFT, RELU_EN, OUT_W);
    assign data = rq.data[OUT_W-1:0];
    // Bits above OUT_W are zero after clamping; folding them in keeps the
    // flag honest should the clamp ever be widened.
    assign sat  = rq.sat | (|rq.data[31:OUT_W]);
endmodule

// File: rtl/fc_tile_accum_layer.sv
// fc_tile_accum_layer: buffers one input vector, loads it row by row into
// v_cim_tiles x h_cim_tiles crossbars, fires the MVM, then reads, sums and
// requantises each output column and emits results one at a time.
//   clk, rst            - clock, async active-low reset
//   i_ibuf_*            - input buffer write port (IDLE only)
//   i_start / o_busy    - start an inference / inference in progress
//   o_cim_we/wr_addr/data, o_cim_start - crossbar row load and MVM trigger
//   i_cim_busy          - crossbar computing
//   o_cim_rd_addr, i_data - column select, column results one cycle later
//   func                - result stream (valid / busy handshake)
module fc_tile_accum_layer
    import cim_pkg::*;
#(
    parameter int input_size           = 256,
    parameter int output_size          = 120,
    parameter int xbar_size            = 512,
    parameter int datatype_size        = 2,
    parameter int acc_size             = 16,
    parameter int output_datatype_size = 2,
    parameter int shift                = 0,
    parameter bit relu_en              = 1'b1,
    localparam int v_cim_tiles = ceil_div(input_size, xbar_size),
    localparam int h_cim_tiles = ceil_div(output_size, xbar_size),
    localparam int IW          = clog2_min1(input_size),
    localparam int XW          = clog2_min1(xbar_size),
    localparam int JW          = clog2_min1(output_size)
) (
    input  logic clk,
    input  logic rst,
    input  logic                     i_ibuf_we,
    input  logic [IW-1:0]            i_ibuf_addr,
    input  logic [datatype_size-1:0] i_ibuf_wr_data,
    input  logic                     i_start,
    output logic                     o_busy,
    output logic                     o_cim_we,
    output logic [XW-1:0]            o_cim_wr_addr,
    output logic [v_cim_tiles-1:0][datatype_size-1:0] o_cim_data,
    output logic                     o_cim_start,
    input  logic                     i_cim_busy,
    output logic [XW-1:0]            o_cim_rd_addr,
    input  logic [v_cim_tiles-1:0][h_cim_tiles-1:0][acc_size-1:0] i_data,
    fc_tile_accum_layer_if.master    func
);
    state_e                          state_q, state_d;
    logic [XW-1:0]                   r_q, r_d;
    logic [JW-1:0]                   j_q, j_d;
    logic [output_datatype_size-1:0] data_q, data_d;
    logic                            sat_q, sat_d;

    logic [datatype_size-1:0]           ibuf [input_size];
    logic [v_cim_tiles-1:0][acc_size-1:0] col;
    logic [output_datatype_size-1:0]    acc_data;
    logic                               acc_sat;

    // Buffer has no reset: its contents survive reset and later inferences.
    always_ff @(posedge clk) begin
        if (state_q == S_IDLE && i_ibuf_we && int'(i_ibuf_addr) < input_size)
            ibuf[i_ibuf_addr] <= i_ibuf_wr_data;
    end

    // Row drive: tile v gets element v*xbar_size+r, zero past the vector end.
    always_comb begin
        int idx;
        idx = 0;
        for (int v = 0; v < v_cim_tiles; v++) begin
            idx           = v * xbar_size + int'(r_q);
            o_cim_data[v] = '0;
            if (state_q == S_LOAD && idx < input_size)
                o_cim_data[v] = ibuf[IW'(idx)];
        end
    end

    // Pick the horizontal tile that holds neuron j from every vertical tile.
    always_comb begin
        int hsel;
        hsel = int'(j_q) / xbar_size;
        for (int v = 0; v < v_cim_tiles; v++) begin
            col[v] = '0;
            for (int hh = 0; hh < h_cim_tiles; hh++)
                if (hh == hsel) col[v] = i_data[v][hh];
        end
    end

    tile_accum #(
        .V(v_cim_tiles), .ACC_W(acc_size), .OUT_W(output_datatype_size),
        .SHIFT(shift), .RELU_EN(relu_en)
    ) u_tile_accum (
        .col(col), .data(acc_data), .sat(acc_sat)
    );

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        j_d     = j_q;
        data_d  = data_q;
        sat_d   = sat_q;
        case (state_q)
            S_IDLE: if (i_start) state_d = S_LOAD;
            S_LOAD: begin
                if (r_q == XW'(xbar_size - 1)) begin
                    r_d     = '0;
                    state_d = S_FIRE;
                end else begin
                    r_d = r_q + 1'b1;
                end
            end
            S_FIRE: state_d = S_WAIT;
            S_WAIT: if (!i_cim_busy) state_d = S_ADDR;
            S_ADDR: state_d = S_CAPT;
            S_CAPT: begin
                data_d  = acc_data;
                sat_d   = acc_sat;
                state_d = S_EMIT;
            end
            S_EMIT: begin
                if (!func.i_next_busy) begin
                    if (j_q == JW'(output_size - 1)) begin
                        j_d     = '0;
                        state_d = S_IDLE;
                    end else begin
                        j_d     = j_q + 1'b1;
                        state_d = S_ADDR;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            r_q     <= '0;
            j_q     <= '0;
            data_q  <= '0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            j_q     <= j_d;
            data_q  <= data_d;
            sat_q   <= sat_d;
        end
    end

    assign o_busy            = (state_q != S_IDLE);
    assign o_cim_we          = (state_q == S_LOAD);
    assign o_cim_wr_addr     = r_q;
    assign o_cim_start       = (state_q == S_FIRE);
    assign o_cim_rd_addr     = XW'(int'(j_q) % xbar_size);
    assign func.o_func_valid = (state_q == S_EMIT);
    assign func.o_func_data  = data_q;
    assign func.o_func_idx   = j_q;
    assign func.o_sat        = sat_q;
endmodule

// File: tb/tb_fc_tile_accum_layer.sv
// Directed bench: two layers share stimulus, one with ReLU and no shift,
// one with ReLU off and shift 1. input_size=6, output_size=2, xbar_size=4
// gives two vertical tiles and one horizontal tile.
module tb_fc_tile_accum_layer;
    localparam int IS = 6, OS = 2, XS = 4, DW = 2, AW = 16, ODW = 2;
    localparam int V = 2, H = 1, IW = 3, XW = 2, JW = 1;

    logic clk = 1'b0, rst = 1'b0;
    logic i_ibuf_we = 1'b0, i_start = 1'b0, i_cim_busy = 1'b0, i_next_busy = 1'b0;
    logic [IW-1:0] i_ibuf_addr = '0;
    logic [DW-1:0] i_ibuf_wr_data = '0;
    logic [V-1:0][H-1:0][AW-1:0] i_data = '0;

    logic o_busy, o_cim_we, o_cim_start;
    logic [XW-1:0] o_cim_wr_addr, o_cim_rd_addr;
    logic [V-1:0][DW-1:0] o_cim_data;
    logic b_busy, b_cim_we, b_cim_start;
    logic [XW-1:0] b_cim_wr_addr, b_cim_rd_addr;
    logic [V-1:0][DW-1:0] b_cim_data;

    fc_tile_accum_layer_if #(.OUT_W(ODW), .IDX_W(JW)) f0 ();
    fc_tile_accum_layer_if #(.OUT_W(ODW), .IDX_W(JW)) f1 ();
    assign f0.i_next_busy = i_next_busy;
    assign f1.i_next_busy = i_next_busy;

    fc_tile_accum_layer #(
        .input_size(IS), .output_size(OS), .xbar_size(XS), .datatype_size(DW),
        .acc_size(AW), .output_datatype_size(ODW), .shift(0), .relu_en(1'b1)
    ) dut (
        .clk(clk), .rst(rst), .i_ibuf_we(i_ibuf_we), .i_ibuf_addr(i_ibuf_addr),
        .i_ibuf_wr_data(i_ibuf_wr_data), .i_start(i_start), .o_busy(o_busy),
        .o_cim_we(o_cim_we), .o_cim_wr_addr(o_cim_wr_addr), .o_cim_data(o_cim_data),
        .o_cim_start(o_cim_start), .i_cim_busy(i_cim_busy),
        .o_cim_rd_addr(o_cim_rd_addr), .i_data(i_data), .func(f0)
    );

    fc_tile_accum_layer #(
        .input_size(IS), .output_size(OS), .xbar_size(XS), .datatype_size(DW),
        .acc_size(AW), .output_datatype_size(ODW), .shift(1), .relu_en(1'b0)
    ) dut2 (
        .clk(clk), .rst(rst), .i_ibuf_we(i_ibuf_we), .i_ibuf_addr(i_ibuf_addr),
        .i_ibuf_wr_data(i_ibuf_wr_data), .i_start(i_start), .o_busy(b_busy),
        .o_cim_we(b_cim_we), .o_cim_wr_addr(b_cim_wr_addr), .o_cim_data(b_cim_data),
        .o_cim_start(b_cim_start), .i_cim_busy(i_cim_busy),
        .o_cim_rd_addr(b_cim_rd_addr), .i_data(i_data), .func(f1)
    );

    always #5 clk = ~clk;

    // Crossbar model: column results appear one cycle after the address.
    logic [AW-1:0] tbl [4][V];
    always @(posedge clk) begin
        for (int v = 0; v < V; v++) i_data[v][0] <= tbl[o_cim_rd_addr][v];
    end

    int n_chk = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic wr(input int a, input int d);
        i_ibuf_we      = 1'b1;
        i_ibuf_addr    = IW'(a);
        i_ibuf_wr_data = DW'(d);
        @(negedge clk);
        i_ibuf_we = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        while (!f0.o_func_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(f0.o_func_valid), 1);
    endtask

    task automatic chk_res(input string tag, input int idx, input int d0, input int s0,
                           input int d1, input int s1);
        chk({tag, "_idx"},   32'(f0.o_func_idx), idx);
        chk({tag, "_data"},  32'(f0.o_func_data), d0);
        chk({tag, "_sat"},   32'(f0.o_sat), s0);
        chk({tag, "_data2"}, 32'(f1.o_func_data), d1);
        chk({tag, "_sat2"},  32'(f1.o_sat), s1);
    endtask

    initial begin
        int exp0 [4] = '{1, 2, 3, 0};
        int exp1 [4] = '{2, 1, 0, 0};
        int vld_seen, cnt;
        logic [ODW-1:0] hold_d;

        for (int i = 0; i < 4; i++) begin
            tbl[i][0] = '0;
            tbl[i][1] = '0;
        end
        repeat (2) @(negedge clk);
        chk("rst_busy",  32'(o_busy), 0);
        chk("rst_we",    32'(o_cim_we), 0);
        chk("rst_start", 32'(o_cim_start), 0);
        chk("rst_valid", 32'(f0.o_func_valid), 0);
        chk("rst_sat",   32'(f0.o_sat), 0);
        chk("rst_addr",  32'({o_cim_wr_addr, o_cim_rd_addr}), 0);
        chk("rst_out",   32'({o_cim_data, f0.o_func_data, f0.o_func_idx}), 0);
        rst = 1'b1;
        @(negedge clk);

        wr(0, 1); wr(1, 2); wr(2, 3); wr(3, 0); wr(4, 2); wr(5, 1);
        wr(7, 3);  // beyond input_size: must be dropped

        // Inference 1: col0 = 5 + -2 = 3, col1 = 7 + 2 = 9
        tbl[0][0] = 16'd5; tbl[0][1] = -16'sd2;
        tbl[1][0] = 16'd7; tbl[1][1] = 16'd2;
        i_cim_busy = 1'b1;
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        chk("busy_rise", 32'(o_busy), 1);
        for (int r = 0; r < XS; r++) begin
            chk($sformatf("load%0d_we", r),   32'(o_cim_we), 1);
            chk($sformatf("load%0d_addr", r), 32'(o_cim_wr_addr), r);
            chk($sformatf("load%0d_d0", r),   32'(o_cim_data[0]), exp0[r]);
            chk($sformatf("load%0d_d1", r),   32'(o_cim_data[1]), exp1[r]);
            @(negedge clk);
        end
        chk("fire_start", 32'(o_cim_start), 1);
        chk("fire_we",    32'(o_cim_we), 0);
        @(negedge clk);
        chk("wait_start", 32'(o_cim_start), 0);

        vld_seen = 0;
        for (int k = 0; k < 10; k++) begin
            if (k == 3) i_start = 1'b1;
            if (k == 4) i_start = 1'b0;
            @(negedge clk);
            if (f0.o_func_valid || o_cim_we) vld_seen++;
        end
        chk("wait_hold", 32'(vld_seen), 0);
        i_cim_busy  = 1'b0;
        i_next_busy = 1'b1;
        @(negedge clk);
        chk("addr_valid", 32'(f0.o_func_valid), 0);
        @(negedge clk);
        chk("capt_valid", 32'(f0.o_func_valid), 0);
        @(negedge clk);
        chk("emit_valid", 32'(f0.o_func_valid), 1);
        chk_res("n0", 0, 3, 0, 1, 0);

        hold_d = f0.o_func_data;
        vld_seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (f0.o_func_valid && f0.o_func_idx == 0 && f0.o_func_data == hold_d) vld_seen++;
        end
        chk("stall_hold", 32'(vld_seen), 4);
        i_next_busy = 1'b0;
        @(negedge clk);
        chk("post_stall_valid", 32'(f0.o_func_valid), 0);
        wait_valid("n1_wait");
        chk_res("n1", 1, 3, 1, 3, 1);
        @(negedge clk);
        chk("done_busy", 32'(o_busy), 0);
        chk("done_valid", 32'(f0.o_func_valid), 0);

        // Inference 2: col0 = -1 + -3 = -4, col1 = 1 + 0 = 1
        tbl[0][0] = -16'sd1; tbl[0][1] = -16'sd3;
        tbl[1][0] = 16'd1;   tbl[1][1] = 16'd0;
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        cnt = 0;
        while (!f0.o_func_valid && cnt < 50) begin
            @(negedge clk);
            cnt++;
        end
        chk("latency", 32'(cnt), XS + 4);
        chk_res("m0", 0, 0, 0, 0, 1);
        @(negedge clk);
        wait_valid("m1_wait");
        chk_res("m1", 1, 1, 0, 0, 0);
        @(negedge clk);
        chk("done2_busy", 32'(o_busy), 0);

        // Reset mid-LOAD at r=2, then rerun from r=0 with retained buffer
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        repeat (2) @(negedge clk);
        chk("pre_rst_addr", 32'(o_cim_wr_addr), 2);
        #2 rst = 1'b0;
        #1;
        chk("arst_busy", 32'(o_busy), 0);
        chk("arst_we",   32'(o_cim_we), 0);
        chk("arst_out",  32'({o_cim_wr_addr, o_cim_data, o_cim_start, f0.o_func_valid}), 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        chk("rerun0_addr", 32'(o_cim_wr_addr), 0);
        chk("rerun0_d",    32'({o_cim_data[1], o_cim_data[0]}), 32'({2'd2, 2'd1}));
        @(negedge clk);
        chk("rerun1_addr", 32'(o_cim_wr_addr), 1);
        chk("rerun1_d",    32'({o_cim_data[1], o_cim_data[0]}), 32'({2'd1, 2'd2}));
        cnt = 0;
        while (o_busy && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        chk("rerun_done", 32'(o_busy), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
